regbank_scoreboard: RTL and testbench

//  Write-pending scoreboard that sequences access to the 32x32 register bank.

---
 rtl/regbank_scoreboard.sv | 137 +++++++++++++
 tb/tb_regbank_scoreboard.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_scoreboard.sv
// Write-pending scoreboard for the 32x32 register bank: tracks issued-but-not-written-back
// writes per register, stalls conflicting issues, and provides drain and flush sequencing.
module regbank_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rs,
    input  logic [ADDR_W-1:0]         issue_rt,
    input  logic                      use_rs,
    input  logic                      use_rt,
    input  logic                      issue_wr,
    input  logic [ADDR_W-1:0]         issue_rd,
    output logic                      issue_ready,
    input  logic                      wb_valid,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic                      flush,
    input  logic                      drain_req,
    output logic                      drained,
    output logic [NUM_REGS-1:0]       busy_mask,
    output logic [ADDR_W+CNT_W-1:0]   pending,
    output logic                      err_underflw
);

    localparam int unsigned PEND_W = ADDR_W + CNT_W;
    localparam logic [CNT_W-1:0] MAXP = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                drained_q, drained_d;
    logic                err_q, err_d;

    logic hz_rs, hz_rt, rd_full;
    logic inc_any, dec_any, underflow;

    // A register is a hazard unless its last outstanding write lands this cycle (write-through bank).
    assign hz_rs = (issue_rs != '0) && (cnt_q[issue_rs] != '0)
                   && !(wb_valid && (wb_addr == issue_rs) && (cnt_q[issue_rs] == ONE));
    assign hz_rt = (issue_rt != '0) && (cnt_q[issue_rt] != '0)
                   && !(wb_valid && (wb_addr == issue_rt) && (cnt_q[issue_rt] == ONE));

    // Saturated counter stalls a new write, unless a writeback to the same register frees a slot now.
    assign rd_full = (issue_rd != '0) && (cnt_q[issue_rd] == MAXP)
                     && !(wb_valid && (wb_addr == issue_rd));

    assign issue_ready = issue_valid && (state_q == ST_RUN) && !flush && !rst
                         && !(use_rs && hz_rs) && !(use_rt && hz_rt) && !(issue_wr && rd_full);

    assign inc_any   = issue_ready && issue_wr && (issue_rd != '0);
    assign dec_any   = !flush && wb_valid && (wb_addr != '0) && (cnt_q[wb_addr] != '0);
    assign underflow = !flush && wb_valid && (wb_addr != '0) && (cnt_q[wb_addr] == '0);

    always_comb begin
        cnt_d[0]  = '0;
        busy_d    = '0;
        err_d     = err_q || underflow;
        pending_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                if (inc_any && (issue_rd == ADDR_W'(r)) && !(dec_any && (wb_addr == ADDR_W'(r)))) begin
                    cnt_d[r] = cnt_q[r] + ONE;
                end else if (dec_any && (wb_addr == ADDR_W'(r)) && !(inc_any && (issue_rd == ADDR_W'(r)))) begin
                    cnt_d[r] = cnt_q[r] - ONE;
                end
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
        if (!flush) begin
            pending_d = pending_q + PEND_W'(inc_any) - PEND_W'(dec_any);
        end
    end

    // Drain: leave RUN on request, return with a pulse once nothing is outstanding.
    always_comb begin
        state_d   = state_q;
        drained_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (drain_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_d = ST_RUN;
                end else if (pending_q == '0) begin
                    state_d   = ST_RUN;
                    drained_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pending_q <= '0;
            busy_q    <= '0;
            drained_q <= 1'b0;
            err_q     <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            drained_q <= drained_d;
            err_q     <= err_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign drained      = drained_q;
    assign busy_mask    = busy_q;
    assign pending      = pending_q;
    assign err_underflw = err_q;

endmodule

// File: tb/tb_regbank_scoreboard.sv
// Testbench for regbank_scoreboard: directed scenarios plus randomized traffic checked
// against a per-register pending-count reference model.
module tb_regbank_scoreboard;

    logic        clk, rst;
    logic        issue_valid, use_rs, use_rt, issue_wr;
    logic [4:0]  issue_rs, issue_rt, issue_rd, wb_addr;
    logic        wb_valid, flush, drain_req;
    logic        issue_ready, drained, err_underflw;
    logic [31:0] busy_mask;
    logic [6:0]  pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt [32];
    bit m_err, m_drain, m_drained;

    regbank_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .use_rs(use_rs), .use_rt(use_rt), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush), .drain_req(drain_req), .drained(drained),
        .busy_mask(busy_mask), .pending(pending), .err_underflw(err_underflw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_hazard(input logic [4:0] a);
        return (a != 0) && (m_cnt[a] != 0) && !(wb_valid && wb_addr == a && m_cnt[a] == 1);
    endfunction

    function automatic bit m_ready();
        bit full;
        if (!issue_valid || m_drain || flush || rst) return 1'b0;
        if (use_rs && m_hazard(issue_rs)) return 1'b0;
        if (use_rt && m_hazard(issue_rt)) return 1'b0;
        full = issue_wr && issue_rd != 0 && m_cnt[issue_rd] == 3 && !(wb_valid && wb_addr == issue_rd);
        return !full;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int r = 0; r < 32; r++) s += m_cnt[r];
        return s;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    task automatic idle();
        issue_valid = 0; use_rs = 0; use_rt = 0; issue_wr = 0;
        issue_rs = 0; issue_rt = 0; issue_rd = 0;
        wb_valid = 0; wb_addr = 0; flush = 0;
    endtask

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic tick();
        bit rdy;
        int sum;
        rdy = m_ready();
        sum = m_sum();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_err = 0; m_drain = 0; m_drained = 0;
        end else begin
            m_drained = 0;
            if (m_drain) begin
                if (!drain_req) m_drain = 0;
                else if (sum == 0) begin m_drain = 0; m_drained = 1; end
            end else if (drain_req) begin
                m_drain = 1;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            end else begin
                if (wb_valid && wb_addr != 0) begin
                    if (m_cnt[wb_addr] == 0) m_err = 1;
                    else m_cnt[wb_addr]--;
                end
                if (rdy && issue_wr && issue_rd != 0) m_cnt[issue_rd]++;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        drain_req = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy_mask !== 32'h0 || pending !== 7'd0 || drained !== 1'b0 || err_underflw !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%h pending=%0d drained=%b err=%b, required 0/0/0/0",
                     busy_mask, pending, drained, err_underflw);
        end
        issue_valid = 1; use_rs = 1; issue_rs = 5'd12; #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: issue_ready=%b, required 1", issue_ready);
        end
        idle();
    endtask

    task automatic test_raw_bypass();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd5;
        tick();
        idle();
        issue_valid = 1; use_rs = 1; issue_rs = 5'd5;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall cycle %0d: issue_ready=%b, required 0", i, issue_ready);
            end
            tick();
        end
        wb_valid = 1; wb_addr = 5'd5; #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_bypass: issue_ready=%b, required 1", issue_ready);
        end
        tick();
        idle();
        checks++;
        if (busy_mask[5] !== 1'b0 || pending !== 7'd0) begin
            errors++;
            $display("FAIL raw_clear: busy5=%b pending=%0d, required 0/0", busy_mask[5], pending);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_issue %0d: issue_ready=%b, required 1", i, issue_ready);
            end
            tick();
        end
        checks++;
        if (pending !== 7'd3 || busy_mask !== 32'h80) begin
            errors++;
            $display("FAIL sat_count: pending=%0d busy=%h, required 3/00000080", pending, busy_mask);
        end
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_stall: issue_ready=%b, required 0", issue_ready);
        end
        tick();
        wb_valid = 1; wb_addr = 5'd7; #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_wb_issue: issue_ready=%b, required 1", issue_ready);
        end
        tick();
        idle();
        checks++;
        if (pending !== 7'd3 || busy_mask[7] !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: pending=%0d busy7=%b, required 3/1", pending, busy_mask[7]);
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 0; use_rs = 1; issue_rs = 0; use_rt = 1; issue_rt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL r0_ready %0d: issue_ready=%b, required 1", i, issue_ready);
            end
            tick();
        end
        idle();
        checks++;
        if (busy_mask !== 32'h0 || pending !== 7'd0) begin
            errors++;
            $display("FAIL r0_untracked: busy=%h pending=%0d, required 0/0", busy_mask, pending);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        wb_valid = 1; wb_addr = 5'd9;
        tick();
        idle();
        checks++;
        if (err_underflw !== 1'b1 || pending !== 7'd0 || busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL underflow_set: err=%b pending=%0d busy=%h, required 1/0/0",
                     err_underflw, pending, busy_mask);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err_underflw !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: err=%b, required 1", err_underflw);
        end
        do_reset();
        checks++;
        if (err_underflw !== 1'b0) begin
            errors++;
            $display("FAIL underflow_rst: err=%b, required 0", err_underflw);
        end
    endtask

    task automatic test_drain();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd3; tick();
        issue_rd = 5'd4; tick();
        idle();
        drain_req = 1;
        tick();
        issue_valid = 1; use_rs = 1; issue_rs = 5'd20; #1;
        checks++;
        if (issue_ready !== 1'b0 || pending !== 7'd2) begin
            errors++;
            $display("FAIL drain_block: issue_ready=%b pending=%0d, required 0/2", issue_ready, pending);
        end
        idle();
        wb_valid = 1; wb_addr = 5'd3; tick();
        wb_addr = 5'd4; tick();
        idle();
        checks++;
        if (pending !== 7'd0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL drain_wait: pending=%0d drained=%b, required 0/0", pending, drained);
        end
        tick();
        checks++;
        if (drained !== 1'b1) begin
            errors++;
            $display("FAIL drain_pulse: drained=%b, required 1", drained);
        end
        drain_req = 0;
        tick();
        checks++;
        if (drained !== 1'b0) begin
            errors++;
            $display("FAIL drain_one_cycle: drained=%b, required 0", drained);
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue_valid = 1; issue_wr = 1;
        for (int r = 1; r <= 5; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        idle();
        checks++;
        if (pending !== 7'd5) begin
            errors++;
            $display("FAIL flush_pre: pending=%0d, required 5", pending);
        end
        flush = 1; wb_valid = 1; wb_addr = 5'd1; issue_valid = 1; #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: issue_ready=%b, required 0", issue_ready);
        end
        tick();
        idle();
        checks++;
        if (pending !== 7'd0 || busy_mask !== 32'h0 || err_underflw !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: pending=%0d busy=%h err=%b, required 0/0/0",
                     pending, busy_mask, err_underflw);
        end
        // flush while draining
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd2; tick();
        idle();
        drain_req = 1; tick();
        flush = 1; tick();
        flush = 0;
        checks++;
        if (pending !== 7'd0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_zero: pending=%0d drained=%b, required 0/0", pending, drained);
        end
        tick();
        checks++;
        if (drained !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain_pulse: drained=%b, required 1", drained);
        end
        drain_req = 0; tick();
        // reset while draining
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd6; tick();
        idle();
        drain_req = 1; tick();
        rst = 1; tick();
        rst = 0; drain_req = 0;
        issue_valid = 1; #1;
        checks++;
        if (issue_ready !== 1'b1 || drained !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: issue_ready=%b drained=%b, required 1/0", issue_ready, drained);
        end
        idle();
        tick();
        checks++;
        if (drained !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_pulse: drained=%b, required 0", drained);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            issue_valid = ($urandom_range(9) < 7);
            use_rs      = $urandom_range(1);
            use_rt      = $urandom_range(1);
            issue_wr    = $urandom_range(1);
            issue_rs    = 5'($urandom_range(7));
            issue_rt    = 5'($urandom_range(7));
            issue_rd    = 5'($urandom_range(7));
            wb_valid    = ($urandom_range(9) < 5);
            wb_addr     = 5'($urandom_range(7));
            flush       = ($urandom_range(49) == 0);
            rst         = ($urandom_range(149) == 0);
            if ($urandom_range(19) == 0) drain_req = ~drain_req;
            #1;
            checks++;
            if (issue_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready cycle %0d: issue_ready=%b, required %b", i, issue_ready, m_ready());
            end
            tick();
            checks++;
            if (pending !== 7'(m_sum()) || busy_mask !== m_busy() ||
                drained !== m_drained || err_underflw !== m_err) begin
                errors++;
                $display("FAIL rand_state cycle %0d: pending=%0d busy=%h drained=%b err=%b, required %0d/%h/%b/%b",
                         i, pending, busy_mask, drained, err_underflw, m_sum(), m_busy(), m_drained, m_err);
            end
        end
        rst = 0;
        drain_req = 0;
        idle();
    endtask

    initial begin
        idle();
        drain_req = 0;
        rst = 1;
        @(negedge clk);
        test_reset();
        test_raw_bypass();
        test_saturation();
        test_reg_zero();
        test_underflow();
        test_drain();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
